// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-side state encoding and PC constants
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, REQ, WAIT, HOLD} state_t;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: issues one imem read per PC, buffers the word for decode, steers the PC register
module pc_fetch_ctrl #(
  parameter int N = 32,
  parameter int PC_STEP = fetch_pkg::PC_STEP,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  pc_in,
  output logic [N-1:0]  pc_next,
  output logic          pc_ena,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst_data,
  output logic [N-1:0]  inst_pc
);
  import fetch_pkg::*;
  state_t state, state_nx;
  logic drop, drop_nx;
  logic [N-1:0] req_pc;
  logic rsp_take, redir_ld, req_lat, iv_clr;
  assign imem_req_valid = (state == REQ);
  assign imem_addr = imem_req_valid ? pc_in : '0;
  // state and drop-pending flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      drop <= 1'b0;
    end else begin
      state <= state_nx;
      drop <= drop_nx;
    end
  // next state and datapath strobes; a redirect overrides every other event
  always_comb begin
    state_nx = state;
    drop_nx = drop;
    rsp_take = 1'b0;
    redir_ld = 1'b0;
    req_lat = 1'b0;
    iv_clr = 1'b0;
    case (state)
      IDLE: state_nx = REQ;
      FLUSH: begin
        redir_ld = redirect_valid;
        state_nx = redirect_valid ? FLUSH : REQ;
      end
      REQ: begin
        req_lat = imem_req_ready;
        redir_ld = redirect_valid;
        drop_nx = redirect_valid && imem_req_ready;
        state_nx = imem_req_ready ? WAIT : (redirect_valid ? FLUSH : REQ);
      end
      WAIT: begin
        if (redirect_valid) begin
          redir_ld = 1'b1;
          drop_nx = !imem_rsp_valid;
          state_nx = imem_rsp_valid ? FLUSH : WAIT;
        end else if (imem_rsp_valid) begin
          rsp_take = !drop;
          drop_nx = 1'b0;
          state_nx = drop ? REQ : HOLD;
        end
      end
      HOLD: begin
        redir_ld = redirect_valid;
        iv_clr = redirect_valid || inst_ready;
        state_nx = redirect_valid ? FLUSH : (inst_ready ? REQ : HOLD);
      end
      default: state_nx = IDLE;
    endcase
  end
  // request PC latch, instruction buffer and PC register drive
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      req_pc <= '0;
      pc_next <= N'(RESET_PC);
      pc_ena <= 1'b0;
      inst_valid <= 1'b0;
      inst_data <= '0;
      inst_pc <= '0;
    end else begin
      if (req_lat) req_pc <= pc_in;
      pc_ena <= redir_ld || rsp_take;
      if (redir_ld) pc_next <= redirect_pc;
      else if (rsp_take) pc_next <= req_pc + N'(PC_STEP);
      if (rsp_take) begin
        inst_valid <= 1'b1;
        inst_data <= imem_rsp_data;
        inst_pc <= req_pc;
      end else if (iv_clr) inst_valid <= 1'b0;
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed checks of fetch sequencing, backpressure, redirect and wrap
module tb_pc_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] pc_in, pc_next, imem_addr, redirect_pc, inst_pc;
  logic [31:0] imem_rsp_data, inst_data;
  logic pc_ena, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic redirect_valid, inst_valid, inst_ready;
  logic outst;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pc_fetch_ctrl #(.N(32), .PC_STEP(4), .IW(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_next(pc_next), .pc_ena(pc_ena),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );
  // PC register model fed by the controller
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc_in <= 32'h0;
    else if (pc_ena) pc_in <= pc_next;
  // outstanding-request tracker for the response protocol assertion
  always_ff @(posedge clk or negedge rst)
    if (!rst) outst <= 1'b0;
    else if (imem_req_valid && imem_req_ready) outst <= 1'b1;
    else if (imem_rsp_valid) outst <= 1'b0;
  always @(posedge clk)
    if (rst) assert (!imem_rsp_valid || outst) else $error("rsp_valid without outstanding request");
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
    tick(); tick();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_pc_ena", {31'b0, pc_ena}, 32'h0);
    chk("rst_pc_next", pc_next, 32'h0);
    rst = 1;
    tick();
    chk("seq_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("seq_addr0", imem_addr, 32'h0);
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1; imem_rsp_data = 32'h2008_0001;
    tick();
    imem_rsp_valid = 0;
    chk("seq_inst_valid", {31'b0, inst_valid}, 32'h1);
    chk("seq_inst_pc", inst_pc, 32'h0);
    chk("seq_inst_data", inst_data, 32'h2008_0001);
    chk("seq_pc_ena", {31'b0, pc_ena}, 32'h1);
    chk("seq_pc_next", pc_next, 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_pc_ena", {31'b0, pc_ena}, 32'h0);
      chk("bp_inst_valid", {31'b0, inst_valid}, 32'h1);
      chk("bp_inst_data", inst_data, 32'h2008_0001);
      chk("bp_inst_pc", inst_pc, 32'h0);
      chk("bp_no_req", {31'b0, imem_req_valid}, 32'h0);
    end
    inst_ready = 1;
    tick();
    inst_ready = 0;
    chk("seq_iv_clear", {31'b0, inst_valid}, 32'h0);
    chk("seq_req2", {31'b0, imem_req_valid}, 32'h1);
    chk("seq_addr4", imem_addr, 32'h4);
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    redirect_valid = 1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 0;
    chk("rw_pc_ena", {31'b0, pc_ena}, 32'h1);
    chk("rw_pc_next", pc_next, 32'h100);
    tick();
    chk("rw_ena_pulse", {31'b0, pc_ena}, 32'h0);
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 0;
    chk("rw_dropped", {31'b0, inst_valid}, 32'h0);
    chk("rw_no_seq_ena", {31'b0, pc_ena}, 32'h0);
    chk("rw_req", {31'b0, imem_req_valid}, 32'h1);
    chk("rw_addr", imem_addr, 32'h100);
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = 32'h1111_1111;
    tick();
    imem_rsp_valid = 0;
    chk("rh_inst_pc", inst_pc, 32'h100);
    chk("rh_pc_next_seq", pc_next, 32'h104);
    inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h40;
    tick();
    inst_ready = 0; redirect_valid = 0;
    chk("rh_pc_next", pc_next, 32'h40);
    chk("rh_pc_ena", {31'b0, pc_ena}, 32'h1);
    chk("rh_iv_clear", {31'b0, inst_valid}, 32'h0);
    chk("rh_flush_no_req", {31'b0, imem_req_valid}, 32'h0);
    tick();
    chk("rh_req", {31'b0, imem_req_valid}, 32'h1);
    chk("rh_addr", imem_addr, 32'h40);
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    #2 rst = 0;
    #1;
    chk("mrst_pc_next", pc_next, 32'h0);
    chk("mrst_pc_ena", {31'b0, pc_ena}, 32'h0);
    chk("mrst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("mrst_inst_data", inst_data, 32'h0);
    chk("mrst_inst_pc", inst_pc, 32'h0);
    chk("mrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("mrst_addr", imem_addr, 32'h0);
    tick();
    rst = 1;
    tick();
    chk("mrst_req", {31'b0, imem_req_valid}, 32'h1);
    chk("mrst_addr0", imem_addr, 32'h0);
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    chk("wrap_redir_next", pc_next, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_ABCD;
    tick();
    imem_rsp_valid = 0;
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_ena", {31'b0, pc_ena}, 32'h1);
    chk("wrap_pc_next", pc_next, 32'h0);
    inst_ready = 1;
    tick();
    inst_ready = 0;
    chk("wrap_addr_next", imem_addr, 32'h0);
    chk("wrap_req", {31'b0, imem_req_valid}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
